mem_split_stage: RTL and testbench

MEM_SPLIT_STAGE -- requirements
Module: mem_split_stage

---
 rtl/mem_split_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_split_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_split_stage.sv
// Memory access split stage.
// Takes one access from address generation. If the access crosses a cache-line
// boundary, it issues two line-local cache requests; otherwise it issues one.
// It waits for one in-order response per accepted request. It then presents
// the merged, right-aligned read data (zero for writes) on the output handshake.
//
// Ports:
//   clk, clr                 clock, asynchronous active-low reset
//   in_valid/in_ready        access handshake; in_addr, in_size, in_wr, in_wdata
//   req_valid/req_ready      cache request handshake; req_addr, req_bytes, req_wr,
//                            req_wdata
//   rsp_valid, rsp_rdata     in-order cache response (ack for writes)
//   out_valid/out_ready      completion handshake; out_rdata, out_split
module mem_split_stage #(
  parameter int unsigned LINE_LG2 = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [1:0]  in_size,
  input  logic        in_wr,
  input  logic [31:0] in_wdata,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  output logic [2:0]  req_bytes,
  output logic        req_wr,
  output logic [31:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_split
);

  localparam int unsigned LineBytes = 1 << LINE_LG2;

  typedef enum logic [2:0] {StIdle, StReqLo, StWaitLo, StReqHi, StWaitHi, StDone} state_e;

  state_e      state_q;
  logic [2:0]  bytes_q;     // total access size
  logic [2:0]  bytes_lo_q;  // bytes in the first (or only) request
  logic        split_q;
  logic [31:0] rsp_lo_q;

  // Zero every byte above the lowest n.
  function automatic logic [31:0] keep_bytes(input logic [31:0] d, input logic [2:0] n);
    case (n)
      3'd1:    return d & 32'h0000_00ff;
      3'd2:    return d & 32'h0000_ffff;
      3'd3:    return d & 32'h00ff_ffff;
      default: return d;
    endcase
  endfunction

  // Decode of the incoming access.
  logic [2:0]        in_bytes;
  logic [LINE_LG2:0] in_end;
  logic              in_split;
  logic [2:0]        in_bytes_lo;

  always_comb begin
    unique case (in_size)
      2'b00:   in_bytes = 3'd1;
      2'b01:   in_bytes = 3'd2;
      default: in_bytes = 3'd4;
    endcase
    in_end      = {1'b0, in_addr[LINE_LG2-1:0]} + (LINE_LG2+1)'(in_bytes);
    in_split    = in_end > (LINE_LG2+1)'(LineBytes);
    in_bytes_lo = in_split ? 3'(LineBytes - 32'(in_addr[LINE_LG2-1:0])) : in_bytes;
  end

  // Second request starts at the next line; wraps at the top of the address space.
  logic [31-LINE_LG2:0] hi_line;
  logic [31:0]          merged;

  assign hi_line = req_addr[31:LINE_LG2] + (32-LINE_LG2)'(1);
  assign merged  = rsp_lo_q |
                   (keep_bytes(rsp_rdata, bytes_q - bytes_lo_q) << {bytes_lo_q, 3'b000});

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= StIdle;
      in_ready   <= 1'b1;
      req_valid  <= 1'b0;
      req_addr   <= '0;
      req_bytes  <= '0;
      req_wr     <= 1'b0;
      req_wdata  <= '0;
      out_valid  <= 1'b0;
      out_rdata  <= '0;
      out_split  <= 1'b0;
      bytes_q    <= '0;
      bytes_lo_q <= '0;
      split_q    <= 1'b0;
      rsp_lo_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            in_ready   <= 1'b0;
            req_valid  <= 1'b1;
            req_addr   <= in_addr;
            req_bytes  <= in_bytes_lo;
            req_wr     <= in_wr;
            req_wdata  <= in_wdata;
            bytes_q    <= in_bytes;
            bytes_lo_q <= in_bytes_lo;
            split_q    <= in_split;
            state_q    <= StReqLo;
          end
        end
        StReqLo: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state_q   <= split_q ? StWaitLo : StWaitHi;
          end
        end
        StWaitLo: begin
          if (rsp_valid) begin
            rsp_lo_q  <= req_wr ? '0 : keep_bytes(rsp_rdata, bytes_lo_q);
            req_valid <= 1'b1;
            req_addr  <= {hi_line, {LINE_LG2{1'b0}}};
            req_bytes <= bytes_q - bytes_lo_q;
            req_wdata <= req_wdata >> {bytes_lo_q, 3'b000};
            state_q   <= StReqHi;
          end
        end
        StReqHi: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state_q   <= StWaitHi;
          end
        end
        StWaitHi: begin
          if (rsp_valid) begin
            out_valid <= 1'b1;
            out_split <= split_q;
            if (req_wr)       out_rdata <= '0;
            else if (split_q) out_rdata <= merged;
            else              out_rdata <= keep_bytes(rsp_rdata, bytes_q);
            state_q <= StDone;
          end
        end
        StDone: begin
          // Back to idle only; the next access is taken the following cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_split_stage.sv
// Testbench for mem_split_stage. It drives a table of accesses and acts as the
// cache. Expected requests and completions go into scoreboard queues at issue
// time and are checked when the design produces them.
module tb_mem_split_stage;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [1:0]  in_size = '0;
  logic        in_wr = 1'b0;
  logic [31:0] in_wdata = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic [2:0]  req_bytes;
  logic        req_wr;
  logic [31:0] req_wdata;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic        out_split;

  always #5 clk = ~clk;

  mem_split_stage #(.LINE_LG2(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_size   (in_size),
    .in_wr     (in_wr),
    .in_wdata  (in_wdata),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_bytes (req_bytes),
    .req_wr    (req_wr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rdata (out_rdata),
    .out_split (out_split)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    int          req_stall;  // cycles req_ready stays low before each handshake
    int          out_hold;   // cycles out_ready stays low in DONE
    logic        junk;       // drive rsp_valid while the stage must ignore it
    logic        split;
    logic [31:0] lo_addr;
    logic [2:0]  lo_bytes;
    logic [31:0] lo_wdata;
    logic [31:0] hi_addr;
    logic [2:0]  hi_bytes;
    logic [31:0] hi_wdata;
    logic [31:0] rdata;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  bytes;
    logic        wr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        split;
  } out_t;

  req_t req_q[$];
  out_t out_q[$];
  vec_t tab[9];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Entered and left at a falling edge; the next access may start immediately.
  task automatic run_vec(input vec_t v);
    req_t        e;
    out_t        o;
    int          stall;
    int          hold;
    int          nresp;
    int          exp_cyc;
    logic        pend;
    logic [31:0] pend_data;
    bit          done;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    chk("out_valid_idle", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_addr  = v.addr;
    in_size  = v.size;
    in_wr    = v.wr;
    in_wdata = v.wdata;
    req_q.push_back('{v.lo_addr, v.lo_bytes, v.wr, v.lo_wdata});
    if (v.split) req_q.push_back('{v.hi_addr, v.hi_bytes, v.wr, v.hi_wdata});
    out_q.push_back('{v.rdata, v.split});
    exp_cyc = v.split ? 4 + 2 * v.req_stall : 2 + v.req_stall;
    @(negedge clk);
    // Scramble the inputs so any unregistered use shows up.
    in_valid = 1'b0;
    in_addr  = ~v.addr;
    in_size  = ~v.size;
    in_wr    = ~v.wr;
    in_wdata = ~v.wdata;
    chk("req_valid_t1", 32'(req_valid), 32'd1);
    stall = 0; hold = 0; nresp = 0; pend = 1'b0; pend_data = '0; done = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      rsp_valid = pend;
      rsp_rdata = pend ? pend_data : 32'hdead_beef;
      pend      = 1'b0;
      if (!rsp_valid && v.junk && (req_valid || out_valid)) rsp_valid = 1'b1;
      req_ready = 1'b0;
      out_ready = 1'b0;
      if (req_valid) begin
        if (req_q.size() == 0) begin
          chk("req_unexpected", 32'(req_valid), 32'd0);
        end else begin
          e = req_q[0];
          chk("req_addr", req_addr, e.addr);
          chk("req_bytes", 32'(req_bytes), 32'(e.bytes));
          chk("req_wr", 32'(req_wr), 32'(e.wr));
          chk("req_wdata", req_wdata, e.wdata);
          if (stall < v.req_stall) begin
            stall++;
          end else begin
            req_ready = 1'b1;
            req_q.delete(0);
            stall     = 0;
            pend      = 1'b1;
            pend_data = (nresp == 0) ? v.rsp_lo : v.rsp_hi;
            nresp++;
          end
        end
      end
      if (out_valid) begin
        if (out_q.size() == 0) begin
          chk("out_unexpected", 32'(out_valid), 32'd0);
        end else begin
          o = out_q[0];
          if (hold == 0) chk("out_latency", 32'(cyc), 32'(exp_cyc));
          chk("in_ready_done", 32'(in_ready), 32'd0);
          chk("out_rdata", out_rdata, o.rdata);
          chk("out_split", 32'(out_split), 32'(o.split));
          if (hold < v.out_hold) begin
            hold++;
          end else begin
            out_ready = 1'b1;
            out_q.delete(0);
            done = 1'b1;
          end
        end
      end
      @(negedge clk);
    end
    rsp_valid = 1'b0;
    req_ready = 1'b0;
    out_ready = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL completion_timeout: got no out handshake, want one for addr 0x%08h", v.addr);
    end
    chk("req_leftover", 32'(req_q.size()), 32'd0);
    req_q.delete();
    out_q.delete();
  endtask

  initial begin
    // addr, size, wr, wdata, rsp_lo, rsp_hi, stall, hold, junk,
    // split, lo_addr, lo_bytes, lo_wdata, hi_addr, hi_bytes, hi_wdata, rdata
    tab[0] = '{32'h0000_1004, 2'd2, 1'b0, 32'h0, 32'haabb_ccdd, 32'h0, 0, 0, 1'b0,
               1'b0, 32'h0000_1004, 3'd4, 32'h0, 32'h0, 3'd0, 32'h0, 32'haabb_ccdd};
    tab[1] = '{32'h0000_100e, 2'd2, 1'b0, 32'h0, 32'h0000_2211, 32'h0000_4433, 0, 0, 1'b0,
               1'b1, 32'h0000_100e, 3'd2, 32'h0, 32'h0000_1010, 3'd2, 32'h0, 32'h4433_2211};
    tab[2] = '{32'hffff_ffff, 2'd1, 1'b1, 32'h0000_beef, 32'h1234_5678, 32'h8765_4321, 0, 0, 1'b0,
               1'b1, 32'hffff_ffff, 3'd1, 32'h0000_beef, 32'h0, 3'd1, 32'h0000_00be, 32'h0};
    tab[3] = '{32'h0000_2000, 2'd1, 1'b0, 32'h0, 32'h9988_7766, 32'h0, 3, 0, 1'b0,
               1'b0, 32'h0000_2000, 3'd2, 32'h0, 32'h0, 3'd0, 32'h0, 32'h0000_7766};
    tab[4] = '{32'h0000_300f, 2'd0, 1'b0, 32'h0, 32'h1234_56ab, 32'h0, 0, 2, 1'b1,
               1'b0, 32'h0000_300f, 3'd1, 32'h0, 32'h0, 3'd0, 32'h0, 32'h0000_00ab};
    tab[5] = '{32'h0000_400d, 2'd3, 1'b0, 32'h0, 32'hff33_2211, 32'heeee_ee44, 0, 0, 1'b0,
               1'b1, 32'h0000_400d, 3'd3, 32'h0, 32'h0000_4010, 3'd1, 32'h0, 32'h4433_2211};
    tab[6] = '{32'h0000_5ffd, 2'd2, 1'b1, 32'ha1b2_c3d4, 32'h1, 32'h2, 1, 0, 1'b1,
               1'b1, 32'h0000_5ffd, 3'd3, 32'ha1b2_c3d4, 32'h0000_6000, 3'd1, 32'h0000_00a1,
               32'h0};
    tab[7] = '{32'h0000_7008, 2'd2, 1'b1, 32'hcafe_f00d, 32'h3, 32'h0, 0, 1, 1'b0,
               1'b0, 32'h0000_7008, 3'd4, 32'hcafe_f00d, 32'h0, 3'd0, 32'h0, 32'h0};
    tab[8] = '{32'h0000_800f, 2'd1, 1'b0, 32'h0, 32'h0055_55aa, 32'h0000_77bb, 0, 0, 1'b0,
               1'b1, 32'h0000_800f, 3'd1, 32'h0, 32'h0000_8010, 3'd1, 32'h0, 32'h0000_bbaa};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_split", 32'(out_split), 32'd0);
    chk("rst_out_rdata", out_rdata, 32'd0);
    chk("rst_req_addr", req_addr, 32'd0);
    chk("rst_req_bytes", 32'(req_bytes), 32'd0);
    chk("rst_req_wdata", req_wdata, 32'd0);
    clr = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(tab[i]);

    // Reset while waiting for the low half of a split read.
    in_valid = 1'b1;
    in_addr  = 32'h0000_100e;
    in_size  = 2'd2;
    in_wr    = 1'b0;
    in_wdata = '0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_req_valid", 32'(req_valid), 32'd1);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = 32'h0000_2211;
    #1 clr = 1'b0;
    #1;
    chk("abort_req_valid_now", 32'(req_valid), 32'd0);
    chk("abort_out_valid_now", 32'(out_valid), 32'd0);
    chk("abort_req_addr_now", req_addr, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_no_req", 32'(req_valid), 32'd0);
      chk("abort_no_out", 32'(out_valid), 32'd0);
    end
    rsp_valid = 1'b0;

    run_vec(tab[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want finish before 200000");
    $fatal(1);
  end

endmodule
